conv_result_writer: RTL
=======================

# conv_result_writer

Output stage directly downstream of the parallel float16 convolution unit. Captures each PARA_X×PARA_Y result tile on the convolution unit's one-cycle result-ready pulse and buffers up to two tiles. Drains the tiles one element per cycle onto a valid/ready memory-write port, computing each element's feature-map address and optionally applying ReLU.

## Interface
- PARA_X, 3, tile rows
- PARA_Y, 3, tile columns
- DATA_WIDTH, 16, float16 element width
- ADDR_WIDTH, 16, write-address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tile_valid  in  1  one-cycle pulse: tile_data/tile_base/row_stride valid (driven by the convolution unit's result_ready)
- tile_data  in  PARA_X*PARA_Y*DATA_WIDTH  tile; element e=x*PARA_Y+y at bits [DATA_WIDTH*(e+1)-1 : DATA_WIDTH*e]
- tile_base  in  ADDR_WIDTH  address of element (0,0)
- row_stride  in  ADDR_WIDTH  address distance between tile rows
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts the write
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- tile_done  out  1  one-cycle pulse after the last element of a tile is accepted
- busy  out  1  FIFO non-empty or a transfer is in progress
- overflow  out  1  sticky: a tile was dropped

## Operation
- 2-entry tile FIFO. Each entry holds tile_data, tile_base and row_stride, all sampled together on tile_valid.
- Two-state FSM:
  - IDLE: wr_valid=0. Moves to SEND when the FIFO is non-empty.
  - SEND: drives the head tile's element e, starting at e=0.
- Element order is x outer, y inner (e ascending).
- Address: wr_addr = tile_base + x*row_stride + y, modulo 2^ADDR_WIDTH. Computed with an incrementing row-base register; no multiplier.
- Handshake: a transfer occurs on a cycle with wr_valid&&wr_ready. Otherwise wr_addr/wr_data/wr_valid hold stable.
- On a transfer of e<PARA_X*PARA_Y-1: e increments and the next element is presented the following cycle.
- On a transfer of the last element:
  - head entry pops and tile_done pulses the next cycle;
  - if another tile is queued, its element 0 is presented the next cycle (no bubble) and the FSM stays in SEND;
  - otherwise the FSM returns to IDLE.
- Push and pop on the same cycle: both succeed, and the count is unchanged.
- Full FIFO:
  - tile_valid with count==2 and no pop that cycle drops the tile and sets overflow;
  - with a pop the same cycle, the tile is accepted.
- overflow clears only on reset.
- busy = (count!=0).

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, tile_done=0, overflow=0, busy=0. FSM=IDLE, FIFO empty, e=0.
- Reset asserted mid-tile: the FIFO and any partial transfer are discarded immediately. No tile_done is generated.
- Latency: tile_valid at edge N into an empty block gives wr_valid=1 with element 0 during cycle N+1.
- With wr_ready held at 1, a tile drains in PARA_X*PARA_Y cycles. tile_done is high in the cycle after the last transfer.
- busy rises in cycle N+1 and falls the cycle after the final pop.
- wr_ready may toggle arbitrarily. The block has no combinational path from wr_ready to any output.

## Configuration
- Macro CONV_RELU_EN.
- Defined: wr_data = 0 when bit DATA_WIDTH-1 (sign) of the element is 1. This covers negatives, -0 and negative NaN. Otherwise the element passes unchanged.
- Undefined: every element passes unchanged. The sign logic is not compiled.

## Test plan
- Single tile, base=0x0100, stride=0x0020, data e=0x3C00+e, wr_ready=1 -> 9 writes, one per cycle, to 0x0100,0x0101,0x0102,0x0120,…,0x0142. tile_done pulses once, then busy=0.
- Back-to-back: two tiles 1 cycle apart, wr_ready=1 -> 18 consecutive writes with no bubble. tile_done pulses after write 9 and after write 18. overflow=0.
- Backpressure: wr_ready toggles 1,0,0,1 repeating -> wr_addr/wr_data remain stable during every stalled cycle. The write sequence is identical to the first scenario.
- Overflow: wr_ready=0, three tile_valid pulses -> overflow=1. After wr_ready=1, only the first two tiles are written (18 writes).
- ReLU: element values 0xBC00, 0x8000, 0x3C00 -> with CONV_RELU_EN writes 0x0000, 0x0000, 0x3C00; without it writes the values unchanged.
- Reset mid-tile after 4 writes -> all outputs return to their reset values. A new tile afterwards starts at element 0 with correct addresses. Address wrap: base=0xFFFF gives wrapped addresses mod 2^16.

Source files
------------

// File: rtl/conv_result_writer.sv
// Result-tile writer: buffers up to two PARA_X x PARA_Y float16 tiles and drains them
// one element per cycle onto a valid/ready write port. Optional ReLU: define CONV_RELU_EN.
module conv_result_writer #(
  parameter int unsigned PARA_X     = 3,
  parameter int unsigned PARA_Y     = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tile_valid,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] tile_data,
  input  logic [ADDR_WIDTH-1:0]               tile_base,
  input  logic [ADDR_WIDTH-1:0]               row_stride,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                tile_done,
  output logic                                busy,
  output logic                                overflow
);

  localparam int unsigned NE = PARA_X * PARA_Y;
  localparam int unsigned TW = NE * DATA_WIDTH;
  localparam int unsigned EW = (NE > 1) ? $clog2(NE) : 1;
  localparam int unsigned YW = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         data_q   [2];
  logic [ADDR_WIDTH-1:0] base_q   [2];
  logic [ADDR_WIDTH-1:0] stride_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic [EW-1:0]         e_q, e_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  tile_done_q, overflow_q;
  logic                  fire, last, pop, push;
  logic [DATA_WIDTH-1:0] elem;

  always_comb begin
    fire = (state_q == SEND) && wr_ready;
    last = (e_q == EW'(NE - 1));
    pop  = fire && last;
    push = tile_valid && ((count_q != 2'd2) || pop);
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // row_base tracks tile_base + x*row_stride; when a tile finishes, the next head
  // is either already queued (count==2) or the tile being pushed this very cycle.
  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          state_d    = SEND;
          row_base_d = base_q[rd_ptr_q];
          e_d        = '0;
          y_d        = '0;
        end else if (push) begin
          state_d    = SEND;
          row_base_d = tile_base;
          e_d        = '0;
          y_d        = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            e_d = '0;
            y_d = '0;
            if (count_q == 2'd2) begin
              row_base_d = base_q[~rd_ptr_q];
            end else if (push) begin
              row_base_d = tile_base;
            end else begin
              state_d = IDLE;
            end
          end else begin
            e_d = e_q + EW'(1);
            if (y_q == YW'(PARA_Y - 1)) begin
              y_d        = '0;
              row_base_d = row_base_q + stride_q[rd_ptr_q];
            end else begin
              y_d = y_q + YW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      e_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i]   <= '0;
        base_q[i]   <= '0;
        stride_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      count_q     <= count_d;
      tile_done_q <= pop;
      if (tile_valid && !push) overflow_q <= 1'b1;
      if (push) begin
        data_q[wr_ptr_q]   <= tile_data;
        base_q[wr_ptr_q]   <= tile_base;
        stride_q[wr_ptr_q] <= row_stride;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_comb begin
    elem = data_q[rd_ptr_q][DATA_WIDTH*int'(e_q) +: DATA_WIDTH];
`ifdef CONV_RELU_EN
    wr_data = elem[DATA_WIDTH-1] ? '0 : elem;
`else
    wr_data = elem;
`endif
  end

  assign wr_valid  = (state_q == SEND);
  assign wr_addr   = row_base_q + ADDR_WIDTH'(y_q);
  assign tile_done = tile_done_q;
  assign busy      = (count_q != 2'd0);
  assign overflow  = overflow_q;

endmodule
